// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 camera bring-up path.
package ov7670_pkg;

    // Configuration sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ROM_CLR  = 4'd1,
        ST_FETCH    = 4'd2,
        ST_DECODE   = 4'd3,
        ST_ISSUE    = 4'd4,
        ST_WAIT_ACK = 4'd5,
        ST_DELAY    = 4'd6,
        ST_ADVANCE  = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } cfg_state_t;

    // Special command ROM entries.
    localparam logic [15:0] CMD_DELAY = 16'hFFF0;
    localparam logic [15:0] CMD_END   = 16'hFFFF;

    // Saturating 8-bit increment used for the write counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// Register-write request bus between the config sequencer and the SCCB master.
interface ov7670_config_sequencer_if;
    logic       sccb_valid;
    logic       sccb_ready;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_data;
    logic       sccb_done;
    logic       sccb_nack;

    // The sequencer requests writes.
    modport master (
        output sccb_valid,
        output sccb_reg,
        output sccb_data,
        input  sccb_ready,
        input  sccb_done,
        input  sccb_nack
    );

    // The SCCB master serves them.
    modport slave (
        input  sccb_valid,
        input  sccb_reg,
        input  sccb_data,
        output sccb_ready,
        output sccb_done,
        output sccb_nack
    );
endinterface

// File: rtl/ov7670_delay_timer.sv
// Load / count-down / expire timer. expired is high while the count is at 1 or 0,
// so a caller that waits for it after loading N spends exactly N cycles counting.
module ov7670_delay_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             expired
);
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_n_s;
    logic             expired_r;

    // Next count: load wins, otherwise decrement while enabled and not yet empty.
    always_comb begin
        cnt_n_s = cnt_r;
        if (load) begin
            cnt_n_s = load_value;
        end else if (en && (cnt_r != {WIDTH{1'b0}})) begin
            cnt_n_s = cnt_r - WIDTH'(1);
        end else begin
            cnt_n_s = cnt_r;
        end
    end

    // Count register and registered expiry flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {WIDTH{1'b0}};
            expired_r <= 1'b1;
        end else begin
            cnt_r     <= cnt_n_s;
            expired_r <= (cnt_n_s <= WIDTH'(1));
        end
    end

    assign expired = expired_r;
endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 startup command ROM and turns each entry into one SCCB write,
// a fixed millisecond delay (FFF0) or end of list (FFFF).
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int DELAY_MS    = 10,
    parameter int MAX_RETRY   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [15:0]                      rom_cmd,
    output logic                             rom_inc,
    output logic                             rom_rst_n,
    ov7670_config_sequencer_if.master        sccb,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [7:0]                       wr_count
);
    localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int DELAY_W      = $clog2(DELAY_CYCLES + 1);
    localparam int RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [DELAY_W-1:0] DELAY_LOAD  = DELAY_W'(DELAY_CYCLES);

    cfg_state_t         state_r;
    cfg_state_t         state_n_s;
    logic [15:0]        cmd_r;
    logic [RETRY_W-1:0] retry_r;
    logic [7:0]         wr_count_r;
    logic               fetch_cnt_r;
    logic               rom_inc_r;
    logic               rom_rst_n_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               pass_start_s;
    logic               bus_ok_s;
    logic               bus_nack_s;
    logic               timer_load_s;
    logic               timer_en_s;
    logic               timer_expired_s;

    ov7670_delay_timer #(
        .WIDTH (DELAY_W)
    ) u_delay_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load_s),
        .load_value (DELAY_LOAD),
        .en         (timer_en_s),
        .expired    (timer_expired_s)
    );

    // Decoded events shared by the FSM and the datapath registers.
    always_comb begin
        pass_start_s = 1'b0;
        bus_ok_s     = 1'b0;
        bus_nack_s   = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR)) begin
            pass_start_s = start;
        end else begin
            pass_start_s = 1'b0;
        end
        if (state_r == ST_WAIT_ACK) begin
            bus_ok_s   = sccb.sccb_done & ~sccb.sccb_nack;
            bus_nack_s = sccb.sccb_done & sccb.sccb_nack;
        end else begin
            bus_ok_s   = 1'b0;
            bus_nack_s = 1'b0;
        end
        timer_load_s = (state_r == ST_DECODE) && (rom_cmd == CMD_DELAY);
        timer_en_s   = (state_r == ST_DELAY);
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (pass_start_s) state_n_s = ST_ROM_CLR;
                else              state_n_s = state_r;
            end
            ST_ROM_CLR:  state_n_s = ST_FETCH;
            // Two cycles: ROM address register, then the registered cmd output.
            ST_FETCH: begin
                if (fetch_cnt_r) state_n_s = ST_DECODE;
                else             state_n_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (rom_cmd == CMD_END)        state_n_s = ST_DONE;
                else if (rom_cmd == CMD_DELAY) state_n_s = ST_DELAY;
                else                           state_n_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (sccb.sccb_ready) state_n_s = ST_WAIT_ACK;
                else                 state_n_s = ST_ISSUE;
            end
            ST_WAIT_ACK: begin
                if (bus_ok_s)                                  state_n_s = ST_ADVANCE;
                else if (bus_nack_s && (retry_r < RETRY_LIMIT)) state_n_s = ST_ISSUE;
                else if (bus_nack_s)                           state_n_s = ST_ERROR;
                else                                           state_n_s = ST_WAIT_ACK;
            end
            ST_DELAY: begin
                if (timer_expired_s) state_n_s = ST_ADVANCE;
                else                 state_n_s = ST_DELAY;
            end
            ST_ADVANCE:  state_n_s = ST_FETCH;
            default:     state_n_s = ST_IDLE;
        endcase
    end

    // State register and FETCH wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fetch_cnt_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            fetch_cnt_r <= (state_r == ST_FETCH) ? ~fetch_cnt_r : 1'b0;
        end
    end

    // Latched command, retry counter and write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r      <= 16'h0000;
            retry_r    <= {RETRY_W{1'b0}};
            wr_count_r <= 8'h00;
        end else begin
            if (state_r == ST_DECODE) cmd_r <= rom_cmd;
            else                      cmd_r <= cmd_r;

            if (pass_start_s || bus_ok_s)                   retry_r <= {RETRY_W{1'b0}};
            else if (bus_nack_s && (retry_r < RETRY_LIMIT)) retry_r <= retry_r + RETRY_W'(1);
            else                                            retry_r <= retry_r;

            if (pass_start_s)  wr_count_r <= 8'h00;
            else if (bus_ok_s) wr_count_r <= sat_inc8(wr_count_r);
            else               wr_count_r <= wr_count_r;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_inc_r   <= 1'b0;
            rom_rst_n_r <= 1'b1;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            rom_inc_r   <= (state_n_s == ST_ADVANCE);
            rom_rst_n_r <= (state_n_s != ST_ROM_CLR);
            valid_r     <= (state_n_s == ST_ISSUE);
            busy_r      <= !(state_n_s inside {ST_IDLE, ST_DONE, ST_ERROR});
            done_r      <= (state_n_s == ST_DONE);
            error_r     <= (state_n_s == ST_ERROR);
        end
    end

    assign rom_inc         = rom_inc_r;
    assign rom_rst_n       = rom_rst_n_r;
    assign sccb.sccb_valid = valid_r;
    assign sccb.sccb_reg   = cmd_r[15:8];
    assign sccb.sccb_data  = cmd_r[7:0];
    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;
    assign wr_count        = wr_count_r;
endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Walks the OV7670 startup command ROM from address 0 and turns each 16-bit entry into one SCCB register write (high byte = register address, low byte = value). `16'hFFF0` entries become a fixed millisecond delay, and `16'hFFFF` ends the list. The block sits between the top-level camera bring-up logic and the SCCB master. It owns the ROM's `inc`/`rst_n` controls and reports busy, done and error status to the top level.

## Interface
- `CLK_FREQ_HZ`, default 25_000_000: `clk` frequency, used for the delay count.
- `DELAY_MS`, default 10: length of the wait for each `FFF0` entry.
- `MAX_RETRY`, default 3: re-issues allowed after a NACK before the block reports an error.
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle pulse; begins a configuration pass.
- `rom_cmd`  in  16: `cmd` output of the command ROM.
- `rom_inc`  out  1: one-cycle pulse that advances the ROM address.
- `rom_rst_n`  out  1: active-low ROM address clear.
- `sccb_valid`  out  1: a write request is pending.
- `sccb_ready`  in  1: the SCCB master accepts the request this cycle.
- `sccb_reg`  out  8: register address.
- `sccb_data`  out  8: register value.
- `sccb_done`  in  1: one-cycle pulse when the bus transaction finishes.
- `sccb_nack`  in  1: qualified by `sccb_done`; 1 means the slave did not acknowledge.
- `busy`  out  1: a configuration pass is in progress.
- `done`  out  1: the pass completed; level, held until the next `start` or `rst`.
- `error`  out  1: retries were exhausted; level, held until the next `start` or `rst`.
- `wr_count`  out  8: number of successful writes in this pass; saturates at 255.

## Operation
- States: IDLE, ROM_CLR, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, ADVANCE, DONE, ERROR.
- IDLE, DONE or ERROR + `start`:
  - go to ROM_CLR;
  - clear `done`, `error`, `wr_count` and the retry counter.
- ROM_CLR: drive `rom_rst_n`=0 for exactly one cycle, then go to FETCH.
- FETCH: wait 2 cycles, because the ROM address register and its registered `cmd` output each add one cycle. Then go to DECODE.
- DECODE: latch `rom_cmd` into the internal command register, then branch on it:
  - `FFFF` → DONE;
  - `FFF0` → DELAY, loading the delay counter;
  - anything else → ISSUE.
- ISSUE:
  - hold `sccb_valid`=1 with `sccb_reg`/`sccb_data` taken from the latched command;
  - when `sccb_valid && sccb_ready`, go to WAIT_ACK; `sccb_valid` is 0 from the next cycle.
- WAIT_ACK on `sccb_done`:
  - `nack`=0: increment `wr_count` (saturating), clear the retry counter, go to ADVANCE.
  - `nack`=1 and retry counter < `MAX_RETRY`: increment the retry counter, return to ISSUE with the same latched command (the ROM is not re-read).
  - `nack`=1 and retry counter = `MAX_RETRY`: go to ERROR.
- DELAY: count down `DELAY_CYCLES` = `CLK_FREQ_HZ/1000*DELAY_MS`, then go to ADVANCE.
- ADVANCE: pulse `rom_inc` for one cycle, then go to FETCH.
- `busy` = 1 in every state except IDLE, DONE and ERROR.
- `start` while busy is ignored.
- A `sccb_done` pulse outside WAIT_ACK is ignored.

## Timing
- Reset values: state IDLE, `rom_inc`=0, `rom_rst_n`=1, `sccb_valid`=0, `sccb_reg`/`sccb_data`=0, `busy`=0, `done`=0, `error`=0, `wr_count`=0.
- All outputs are registered.
- `rst` asserted mid-operation: `sccb_valid` drops asynchronously; the SCCB master is responsible for aborting any in-flight transfer.
- `start` → `rom_rst_n` low: 1 cycle.
- Per entry, excluding bus time: `start`/ADVANCE → DECODE takes 3 cycles; DECODE → `sccb_valid` takes 1 cycle.
- `sccb_reg`/`sccb_data` are stable from `sccb_valid` rising until the handshake completes.
- `FFF0` entry: exactly `DELAY_CYCLES` cycles in DELAY.
- `rom_inc` and `rom_rst_n` are never asserted in the same cycle.
- Delay counter width: `$clog2(DELAY_CYCLES+1)`.
- Retry counter width: `$clog2(MAX_RETRY+1)`.

## Structure
- Shared package `ov7670_pkg`:
  - state enum `cfg_state_t`;
  - `CMD_DELAY` = `16'hFFF0`;
  - `CMD_END` = `16'hFFFF`.
- Natural sub-module: `ov7670_delay_timer`, a load/count-down/expire counter, reusable by the capture path.
- The ROM and the SCCB master are instantiated by the parent, not inside this block.

## Test plan
- Three-entry ROM model `1280`, `FFF0`, `FFFF`; `start`; master always ready/ACK:
  - exactly one write, reg=0x12, data=0x80;
  - then `DELAY_CYCLES` idle cycles;
  - then `done`=1, `busy`=0, `wr_count`=1.
- Full 75-entry startup table: 73 writes in ROM order with matching reg/data; `done` set; `wr_count`=73.
- `sccb_ready` held low 20 cycles: `sccb_valid` and its data stay stable; exactly one transaction is counted.
- NACK twice on entry 2 (`1204`), then ACK:
  - reg 0x12 / data 0x04 is issued 3 times;
  - `rom_inc` is not pulsed during the retries;
  - final `wr_count`=75-2 with no error.
- NACK 4 times with `MAX_RETRY`=3: `error`=1, `busy`=0, no further `rom_inc`; a new `start` restarts from address 0 with `error` cleared.
- `rst` asserted while in WAIT_ACK, then `start`: all outputs return to their reset values immediately; the pass restarts from entry 0 and completes.
